// File: rtl/seq_gen_01000101.sv
// Bit-serial pattern transmitter: on a rising start request, shifts an 8-bit pattern out MSB-first.
// Optional feature: define PATTERN_SW_EN to take the frame pattern from SW[9:2] instead of PATTERN.
module seq_gen_01000101 #(
  parameter logic [7:0] PATTERN = 8'b01000101,
  parameter int         LEN     = 8
) (
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [2:0] LEDG,
  output logic [2:0] LEDR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] LAST = 3'(LEN - 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic       unused;

  // The pushbutton acts on its press (falling edge), so the inverted key is the clock.
  assign clk   = ~KEY[3];
  assign rst_n = SW[1];
  assign start = SW[0];

`ifdef PATTERN_SW_EN
  assign pattern = SW[9:2];
  assign unused  = &{1'b0, KEY[2:0]};
`else
  assign pattern = PATTERN;
  assign unused  = &{1'b0, KEY[2:0], SW[9:2]};
`endif

  state_t     state, state_d;
  logic [7:0] sr, sr_d;
  logic [2:0] cnt, cnt_d;
  logic       start_q;
  logic       trig;

  logic       line_q, line_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic [2:0] idx_q, idx_d;

  assign trig = start & ~start_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (trig) begin
          sr_d    = pattern;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d = {sr[6:0], 1'b0};
        if (cnt == LAST) begin
          cnt_d   = 3'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    line_d  = (state_d == SHIFT) ? sr_d[7] : 1'b1;
    valid_d = (state_d == SHIFT);
    done_d  = (state_d == DONE);
    idx_d   = (state_d == SHIFT) ? cnt_d : 3'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state   <= IDLE;
      sr      <= 8'h00;
      cnt     <= 3'd0;
      start_q <= 1'b0;
      line_q  <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state   <= state_d;
      sr      <= sr_d;
      cnt     <= cnt_d;
      start_q <= start;
      line_q  <= line_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  assign LEDG = {done_q, valid_q, line_q};
  assign LEDR = idx_q;

endmodule
